// File: rtl/arb_pkg.sv
// Shared types for the round-robin stream arbiter: FSM states, the grant
// vector type and a one-hot to index helper.
package arb_pkg;

  localparam int c_max_req = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  typedef logic [c_max_req-1:0] gnt_vec_t;

  function automatic int onehot_to_idx(input gnt_vec_t v);
    int idx;
    idx = 0;
    for (int i = 0; i < c_max_req; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester inside the priority mask,
// falling back to the lowest requester overall when the mask selects nobody.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int p_num_req  = 4,
  localparam int p_src_bits = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic [p_num_req-1:0]  req,
  input  logic [p_num_req-1:0]  mask,
  output logic [p_num_req-1:0]  gnt,
  output logic [p_src_bits-1:0] idx
);

  localparam logic [p_num_req-1:0] c_one = p_num_req'(1);

  logic [p_num_req-1:0] masked;
  logic [p_num_req-1:0] cand;
  gnt_vec_t             gnt_wide;

  // cand & -cand isolates the lowest set bit
  always_comb begin
    masked   = req & mask;
    cand     = (|masked) ? masked : req;
    gnt      = cand & (~cand + c_one);
    gnt_wide = '0;
    gnt_wide[p_num_req-1:0] = gnt;
    idx      = p_src_bits'(onehot_to_idx(gnt_wide));
  end

endmodule

// File: rtl/rr_stream_arb.sv
// N-input valid/ready stream arbiter with round-robin priority, packet locking
// and a registered one-entry output stage.
module rr_stream_arb
  import arb_pkg::*;
#(
  parameter  int p_num_req  = 4,
  parameter  int p_msg_bits = 32,
  localparam int p_src_bits = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [p_num_req-1:0]            req_val,
  output logic [p_num_req-1:0]            req_rdy,
  input  logic [p_num_req*p_msg_bits-1:0] req_msg,
  input  logic [p_num_req-1:0]            req_last,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [p_msg_bits-1:0]           out_msg,
  output logic                            out_last,
  output logic [p_src_bits-1:0]           out_src,
  output logic                            busy
);

  arb_state_t             state;
  logic [p_src_bits-1:0]  lock_idx;
  logic [p_num_req-1:0]   pick_gnt;
  logic [p_src_bits-1:0]  pick_idx;
  logic [p_num_req-1:0]   lock_oh;
  logic [p_num_req-1:0]   sel_oh;
  logic [p_src_bits-1:0]  sel_idx;
  logic [p_msg_bits-1:0]  sel_msg;
  logic                   sel_last;
  logic                   load;
  logic                   accept;

  assign load = ~out_val | out_rdy;

  // While locked only the owning requester is offered rdy, regardless of val
  always_comb begin
    lock_oh = '0;
    for (int i = 0; i < p_num_req; i++) begin
      lock_oh[i] = (lock_idx == p_src_bits'(i));
    end
    sel_oh   = (state == LOCKED) ? lock_oh : pick_gnt;
    sel_idx  = (state == LOCKED) ? lock_idx : pick_idx;
    req_rdy  = sel_oh & {p_num_req{load}};
    accept   = |(req_val & req_rdy);
    sel_last = |(sel_oh & req_last);
    sel_msg  = '0;
    for (int i = 0; i < p_num_req; i++) begin
      if (sel_oh[i]) sel_msg = req_msg[i*p_msg_bits +: p_msg_bits];
    end
  end

  generate
    if (p_num_req > 1) begin : g_rr
      logic [p_num_req-1:0] prio_mask;

      // Advance past whichever source just completed a packet
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prio_mask <= '1;
        end else if (accept && sel_last) begin
          for (int i = 0; i < p_num_req; i++) begin
            prio_mask[i] <= (i > int'(sel_idx));
          end
        end
      end

      rr_pick #(
        .p_num_req(p_num_req)
      ) u_pick (
        .req (req_val),
        .mask(prio_mask),
        .gnt (pick_gnt),
        .idx (pick_idx)
      );
    end else begin : g_single
      assign pick_gnt = req_val;
      assign pick_idx = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_idx <= '0;
      out_val  <= 1'b0;
      out_msg  <= '0;
      out_last <= 1'b0;
      out_src  <= '0;
    end else begin
      if (accept) begin
        out_val  <= 1'b1;
        out_msg  <= sel_msg;
        out_last <= sel_last;
        out_src  <= sel_idx;
        if (sel_last) begin
          state <= IDLE;
        end else begin
          state    <= LOCKED;
          lock_idx <= sel_idx;
        end
      end else if (out_rdy) begin
        out_val <= 1'b0;
      end
    end
  end

  assign busy = (state == LOCKED) | out_val;

endmodule

// File: tb/tb_rr_stream_arb.sv
// Self-checking bench for rr_stream_arb: directed scenarios plus randomized
// traffic against a queue-free arithmetic reference model; also a 1-input instance.
module tb_rr_stream_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_val, req_rdy, req_last;
  logic [N*W-1:0] req_msg;
  logic           out_val, out_rdy, out_last, busy;
  logic [W-1:0]   out_msg;
  logic [1:0]     out_src;

  logic           s_req_val, s_req_rdy, s_req_last;
  logic [W-1:0]   s_req_msg, s_out_msg;
  logic           s_out_val, s_out_rdy, s_out_last, s_busy;
  logic [0:0]     s_out_src;

  int errors = 0;
  int checks = 0;

  // Reference model: next priority index, lock owner and the output register
  int           m_next, m_lock;
  bit           m_locked, m_ov, m_last;
  logic [W-1:0] m_msg;
  logic [1:0]   m_src;
  logic [N-1:0] m_rdy;
  logic [N-1:0] last_hs;

  always #5 clk = ~clk;

  rr_stream_arb #(.p_num_req(N), .p_msg_bits(W)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .req_last(req_last), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  rr_stream_arb #(.p_num_req(1), .p_msg_bits(W)) dut1 (
    .clk(clk), .rst(rst), .req_val(s_req_val), .req_rdy(s_req_rdy), .req_msg(s_req_msg),
    .req_last(s_req_last), .out_val(s_out_val), .out_rdy(s_out_rdy), .out_msg(s_out_msg),
    .out_last(s_out_last), .out_src(s_out_src), .busy(s_busy)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_next = 0; m_lock = 0; m_locked = 0; m_ov = 0;
    m_msg = '0; m_last = 0; m_src = '0; m_rdy = '0;
  endtask

  task automatic model_rdy();
    bit ld;
    int i;
    ld = !m_ov || out_rdy;
    m_rdy = '0;
    if (m_locked) begin
      if (ld) m_rdy[m_lock] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (m_next + k) % N;
        if (req_val[i]) begin
          if (ld) m_rdy[i] = 1'b1;
          break;
        end
      end
    end
  endtask

  // One clock: update the model from the pre-edge inputs, end at the next negedge
  task automatic tick();
    logic [N-1:0] acc;
    logic [W-1:0] msg;
    int           src;
    bit           lst;
    model_rdy();
    acc     = req_val & m_rdy;
    last_hs = req_val & req_rdy;
    src     = 0;
    for (int i = 0; i < N; i++) if (acc[i]) src = i;
    msg = req_msg[src*W +: W];
    lst = req_last[src];
    @(posedge clk);
    if (|acc) begin
      m_ov = 1; m_msg = msg; m_last = lst; m_src = 2'(src);
      if (lst) begin
        m_locked = 0;
        m_next   = (src + 1) % N;
      end else begin
        m_locked = 1;
        m_lock   = src;
      end
    end else if (out_rdy) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_val = '0; req_last = '0; req_msg = '0; out_rdy = 0;
    s_req_val = 0; s_req_last = 0; s_req_msg = '0; s_out_rdy = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    req_val = '0; req_last = '0; req_msg = '0; out_rdy = 0;
    s_req_val = 0; s_req_last = 0; s_req_msg = '0; s_out_rdy = 0;
    rst = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_val got=%b exp=0", out_val); end
    checks++; if (out_msg !== '0) begin errors++; $display("[TB] FAIL reset_out_msg got=%h exp=0", out_msg); end
    checks++; if (out_last !== 1'b0 || out_src !== 2'd0) begin errors++; $display("[TB] FAIL reset_last_src got=%b/%0d exp=0/0", out_last, out_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL reset_idle_rdy got=%b exp=0000", req_rdy); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_src[5];
    exp_src = '{0, 1, 2, 3, 0};
    do_reset();
    out_rdy = 1;
    for (int i = 0; i < N; i++) req_msg[i*W +: W] = 32'hA0 + 32'(i);
    req_last = '1;
    req_val  = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      model_rdy();
      checks++; if (req_rdy !== m_rdy) begin errors++; $display("[TB] FAIL rr_rdy cyc=%0d got=%b exp=%b", c, req_rdy, m_rdy); end
      if (c >= 1) begin
        checks++;
        if (out_val !== 1'b1 || out_src !== 2'(exp_src[c-1]) || out_msg !== 32'hA0 + 32'(exp_src[c-1])) begin
          errors++;
          $display("[TB] FAIL rr_out cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_val, out_src, out_msg,
                   exp_src[c-1], 32'hA0 + 32'(exp_src[c-1]));
        end
      end
      tick();
    end
    req_val = '0;
  endtask

  task automatic test_packet_lock();
    int           exp_src[5];
    logic [W-1:0] exp_msg[5];
    int           b;
    bit           done0, done2;
    exp_src = '{1, 1, 1, 2, 0};
    exp_msg = '{32'hB0, 32'hB1, 32'hB2, 32'hC2, 32'hC0};
    do_reset();
    out_rdy = 1;
    b = 0; done0 = 0; done2 = 0;
    req_msg[0*W +: W] = 32'hC0; req_last[0] = 1;
    req_msg[2*W +: W] = 32'hC2; req_last[2] = 1;
    for (int c = 0; c < 7; c++) begin
      req_val[1] = (b < 3);
      req_msg[1*W +: W] = 32'hB0 + 32'(b);
      req_last[1] = (b == 2);
      req_val[0] = (c >= 1) && !done0;
      req_val[2] = (c >= 1) && !done2;
      #1;
      model_rdy();
      checks++; if (req_rdy !== m_rdy) begin errors++; $display("[TB] FAIL lock_rdy cyc=%0d got=%b exp=%b", c, req_rdy, m_rdy); end
      if (c == 1 || c == 2) begin
        checks++;
        if (req_rdy[0] !== 1'b0 || req_rdy[2] !== 1'b0) begin
          errors++; $display("[TB] FAIL lock_others cyc=%0d got=%b exp=x0x0 on bits 0,2", c, req_rdy);
        end
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (out_val !== 1'b1 || out_src !== 2'(exp_src[c-1]) || out_msg !== exp_msg[c-1]) begin
          errors++;
          $display("[TB] FAIL lock_out cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_val, out_src, out_msg,
                   exp_src[c-1], exp_msg[c-1]);
        end
      end
      tick();
      if (last_hs[1]) b++;
      if (last_hs[0]) done0 = 1;
      if (last_hs[2]) done2 = 1;
    end
    req_val = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 0;
    req_val = 4'b0001; req_msg[0*W +: W] = 32'h55; req_last = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("[TB] FAIL bp_first_rdy got=%b exp=0001", req_rdy); end
    tick();
    req_val = 4'b1000; req_msg[3*W +: W] = 32'h33;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL bp_stall_rdy cyc=%0d got=%b exp=0000", c, req_rdy); end
      checks++;
      if (out_val !== 1'b1 || out_msg !== 32'h55 || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_stall_out cyc=%0d got=%b/%h/%b exp=1/55/1", c, out_val, out_msg, busy);
      end
      tick();
    end
    out_rdy = 1;
    #1;
    checks++; if (req_rdy !== 4'b1000) begin errors++; $display("[TB] FAIL bp_release_rdy got=%b exp=1000", req_rdy); end
    tick();
    req_val = '0;
    #1;
    checks++;
    if (out_val !== 1'b1 || out_msg !== 32'h33 || out_src !== 2'd3) begin
      errors++; $display("[TB] FAIL bp_refill got=%b/%h/%0d exp=1/33/3", out_val, out_msg, out_src);
    end
    tick();
    #1;
    checks++; if (out_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got=%b/%b exp=0/0", out_val, busy); end
    @(negedge clk);
  endtask

  task automatic test_wrap_sparse();
    bit           pat[6];
    logic [N-1:0] exp_rdy[6];
    bit           exp_ov[5];
    int           exp_src[5];
    pat     = '{1, 1, 0, 1, 1, 0};
    exp_rdy = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
    exp_ov  = '{1, 1, 0, 1, 1};
    exp_src = '{0, 3, 0, 0, 3};
    do_reset();
    out_rdy = 1;
    req_msg[0*W +: W] = 32'hE0; req_msg[3*W +: W] = 32'hE3; req_last = '1;
    for (int c = 0; c < 6; c++) begin
      req_val = pat[c] ? 4'b1001 : 4'b0000;
      #1;
      checks++; if (req_rdy !== exp_rdy[c]) begin errors++; $display("[TB] FAIL wrap_rdy cyc=%0d got=%b exp=%b", c, req_rdy, exp_rdy[c]); end
      if (c >= 1) begin
        checks++;
        if (out_val !== exp_ov[c-1] || (exp_ov[c-1] && out_src !== 2'(exp_src[c-1]))) begin
          errors++; $display("[TB] FAIL wrap_out cyc=%0d got=%b/%0d exp=%b/%0d", c, out_val, out_src, exp_ov[c-1], exp_src[c-1]);
        end
      end
      tick();
    end
    req_val = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_rdy = 1;
    req_val = 4'b0100; req_msg[2*W +: W] = 32'h20; req_last = 4'b0000;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("[TB] FAIL ar_first_rdy got=%b exp=0100", req_rdy); end
    tick();
    req_msg[2*W +: W] = 32'h21;
    #1;
    checks++; if (busy !== 1'b1 || out_val !== 1'b1) begin errors++; $display("[TB] FAIL ar_midpkt got=%b/%b exp=1/1", busy, out_val); end
    rst = 1;
    #1;
    checks++; if (out_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_async_clear got=%b/%b exp=0/0", out_val, busy); end
    model_reset();
    @(negedge clk);
    rst = 0;
    req_val = 4'b0101; req_last = 4'b1111;
    req_msg[0*W +: W] = 32'h30; req_msg[2*W +: W] = 32'h22;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("[TB] FAIL ar_after_rdy got=%b exp=0001", req_rdy); end
    tick();
    req_val = 4'b0100;
    #1;
    checks++; if (out_src !== 2'd0 || out_msg !== 32'h30) begin errors++; $display("[TB] FAIL ar_after_out got=%0d/%h exp=0/30", out_src, out_msg); end
    tick();
    req_val = '0;
    #1;
    checks++; if (out_src !== 2'd2 || out_msg !== 32'h22) begin errors++; $display("[TB] FAIL ar_second_out got=%0d/%h exp=2/22", out_src, out_msg); end
    tick();
  endtask

  task automatic test_random();
    int left[N];
    do_reset();
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int c = 0; c < 400; c++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_val[i] && $urandom_range(0, 2) == 0) begin
          left[i] = $urandom_range(1, 3);
          req_val[i] = 1'b1;
          req_msg[i*W +: W] = $urandom;
          req_last[i] = (left[i] == 1);
        end
      end
      #1;
      model_rdy();
      checks++; if (req_rdy !== m_rdy) begin errors++; $display("[TB] FAIL rnd_rdy cyc=%0d got=%b exp=%b", c, req_rdy, m_rdy); end
      checks++;
      if (out_val !== m_ov || busy !== (m_locked || m_ov)) begin
        errors++; $display("[TB] FAIL rnd_val_busy cyc=%0d got=%b/%b exp=%b/%b", c, out_val, busy, m_ov, m_locked || m_ov);
      end
      if (m_ov) begin
        checks++;
        if (out_msg !== m_msg || out_last !== m_last || out_src !== m_src) begin
          errors++;
          $display("[TB] FAIL rnd_out cyc=%0d got=%h/%b/%0d exp=%h/%b/%0d", c, out_msg, out_last, out_src, m_msg, m_last, m_src);
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (last_hs[i]) begin
          left[i]--;
          if (left[i] > 0) begin
            req_msg[i*W +: W] = $urandom;
            req_last[i] = (left[i] == 1);
          end else begin
            req_val[i] = 1'b0;
          end
        end
      end
    end
    req_val = '0;
    out_rdy = 1;
    tick();
    tick();
  endtask

  task automatic test_single();
    int sent, got, c;
    bit done, hs;
    do_reset();
    sent = 0; got = 0; c = 0; done = 0;
    while (!done && c < 60) begin
      s_req_val  = (sent < 5);
      s_req_msg  = 32'hD0 + 32'(sent);
      s_req_last = (sent == 4);
      s_out_rdy  = (c % 2 == 0);
      #1;
      if (c == 1) begin
        checks++; if (s_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_on got=%b exp=1", s_busy); end
      end
      if (got == 5) begin
        checks++;
        if (s_busy !== 1'b0 || s_out_val !== 1'b0) begin
          errors++; $display("[TB] FAIL single_busy_off got=%b/%b exp=0/0", s_busy, s_out_val);
        end
        done = 1;
      end else if (s_out_val && s_out_rdy) begin
        checks++;
        if (s_out_msg !== 32'hD0 + 32'(got) || s_out_src !== 1'b0 || s_out_last !== (got == 4)) begin
          errors++;
          $display("[TB] FAIL single_beat idx=%0d got=%h/%0d/%b exp=%h/0/%b", got, s_out_msg, s_out_src, s_out_last,
                   32'hD0 + 32'(got), got == 4);
        end
        got++;
      end
      hs = s_req_val && s_req_rdy;
      @(posedge clk);
      if (hs) sent++;
      @(negedge clk);
      c++;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL single_timeout got=%0d beats exp=5", got);
    end
    s_req_val = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap_sparse();
    test_async_reset();
    test_random();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
